// File: rtl/vector_bank_memory_if.sv
// Request/response bus between the vector load/store unit and the bank memory.
// A beat transfers when valid && ready are both high at a rising clk edge; valid,
// and every field it qualifies, hold stable until that edge.
interface vector_bank_memory_if #(
   parameter int AW    = 20,
   parameter int DW    = 8,
   parameter int LANES = 8
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [AW-1:0]         req_addr;
   logic [LANES*DW-1:0]   req_wdata;
   logic [LANES-1:0]      req_wmask;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [LANES*DW-1:0]   rsp_rdata;
   logic                  rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/vector_bank_memory.sv
// Histogram region plus NUM_BANKS image banks in one flat element space, served as
// LANES-wide masked vector accesses, with a free-running display scan read port.
module vector_bank_memory #(
   parameter int DW         = 8,
   parameter int LANES      = 8,
   parameter int HIST_DEPTH = 512,
   parameter int NUM_BANKS  = 5,
   parameter int BANK_DEPTH = 65536,
   parameter int AW         = 20
) (
   input  logic                   clk,
   input  logic                   rst_n,
   vector_bank_memory_if.slave    bus,
   input  logic                   scan_en,
   output logic                   scan_valid,
   output logic [DW-1:0]          scan_pixel,
   output logic                   scan_sof
);
   localparam int LOG2L      = $clog2(LANES);
   localparam int TOTAL      = HIST_DEPTH + NUM_BANKS * BANK_DEPTH;
   localparam int SCAN_TOTAL = NUM_BANKS * BANK_DEPTH;
   localparam int ROWS       = TOTAL / LANES;
   localparam int HIST_ROWS  = HIST_DEPTH / LANES;
   localparam int ROW_W      = $clog2(ROWS);
   localparam logic [AW:0]   TOTAL_W   = (AW+1)'(TOTAL);
   localparam logic [AW-1:0] SCAN_LAST = AW'(SCAN_TOTAL - 1);

   if ((longint'(HIST_DEPTH) + longint'(NUM_BANKS) * longint'(BANK_DEPTH)) > (longint'(1) << AW)
       || LANES < 2 || (LANES & (LANES - 1)) != 0 || NUM_BANKS < 1
       || (HIST_DEPTH % LANES) != 0 || (BANK_DEPTH % LANES) != 0) begin : g_param_check
      $error("vector_bank_memory: illegal parameter combination");
   end

   // Storage is lane-interleaved: element A lives in lane A%LANES, row A/LANES.
   // Regions are contiguous, so an aligned address maps straight to a row.
   logic [DW-1:0] mem [LANES][ROWS];

   logic              misaligned;
   logic              out_of_range;
   logic              bad;
   logic              accept;
   logic              wr_en;
   logic [ROW_W-1:0]  req_row;
   logic [LANES*DW-1:0] rd_word;

   assign bus.req_ready = rst_n && (!bus.rsp_valid || bus.rsp_ready);

   always_comb begin
      misaligned   = bus.req_addr[LOG2L-1:0] != '0;
      // Compare in AW+1 bits so a space filling all of 2^AW never wraps.
      out_of_range = {1'b0, bus.req_addr} >= TOTAL_W;
      bad          = misaligned || out_of_range;
      accept       = bus.req_valid && bus.req_ready;
      wr_en        = accept && bus.req_we && !bad;
      req_row      = ROW_W'(bus.req_addr >> LOG2L);
   end

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < LANES; i++) begin
         rd_word[i*DW +: DW] = mem[i][req_row];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < LANES; i++) begin
            if (bus.req_wmask[i]) begin
               mem[i][req_row] <= bus.req_wdata[i*DW +: DW];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
      end else if (accept) begin
         bus.rsp_valid <= 1'b1;
         bus.rsp_err   <= bad;
         bus.rsp_rdata <= (bad || bus.req_we) ? '0 : rd_word;
      end else if (bus.rsp_ready) begin
         bus.rsp_valid <= 1'b0;
      end
   end

   logic [AW-1:0]    scan_ptr;
   logic [LOG2L-1:0] scan_lane;
   logic [ROW_W-1:0] scan_row;

   // Scan index 0 is the first element of bank 0; HIST_DEPTH is lane aligned,
   // so the lane comes straight from the low pointer bits.
   always_comb begin
      scan_lane = scan_ptr[LOG2L-1:0];
      scan_row  = ROW_W'(HIST_ROWS) + ROW_W'(scan_ptr >> LOG2L);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_ptr   <= '0;
         scan_valid <= 1'b0;
         scan_pixel <= '0;
         scan_sof   <= 1'b0;
      end else if (scan_en) begin
         scan_pixel <= mem[scan_lane][scan_row];
         scan_valid <= 1'b1;
         scan_sof   <= scan_ptr == '0;
         scan_ptr   <= (scan_ptr == SCAN_LAST) ? '0 : scan_ptr + 1'b1;
      end else begin
         scan_valid <= 1'b0;
         scan_sof   <= 1'b0;
      end
   end
endmodule

// File: tb/tb_vector_bank_memory.sv
// Randomised scoreboard bench for vector_bank_memory against a flat element-array model,
// run on a reduced geometry so a full display scan wraps quickly.
module tb_vector_bank_memory;
   localparam int DW         = 8;
   localparam int LANES      = 8;
   localparam int HIST       = 64;
   localparam int NB         = 3;
   localparam int BD         = 128;
   localparam int AW         = 10;
   localparam int TOTAL      = HIST + NB * BD;
   localparam int SCAN_TOTAL = NB * BD;
   localparam int W          = LANES * DW + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          scan_en = 1'b0;
   logic          scan_valid;
   logic [DW-1:0] scan_pixel;
   logic          scan_sof;

   vector_bank_memory_if #(.AW(AW), .DW(DW), .LANES(LANES)) bus ();

   vector_bank_memory #(
      .DW(DW), .LANES(LANES), .HIST_DEPTH(HIST), .NUM_BANKS(NB), .BANK_DEPTH(BD), .AW(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .scan_en(scan_en),
      .scan_valid(scan_valid), .scan_pixel(scan_pixel), .scan_sof(scan_sof)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic rand_ready = 1'b0;

   logic [DW-1:0] ref_mem [TOTAL];
   int            scan_ptr_m = 0;
   logic [DW-1:0] last_pix = '0;
   logic [W-1:0]  exp_q[$];
   logic [DW:0]   scan_q[$];

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: element-level semantics of one accepted request.
   task automatic accept_model(input logic we, input logic [AW-1:0] addr,
                               input logic [LANES*DW-1:0] wdata, input logic [LANES-1:0] wmask);
      logic [LANES*DW-1:0] rd;
      int a;
      a  = int'(addr);
      rd = '0;
      if ((a % LANES) != 0 || a >= TOTAL) begin
         exp_q.push_back({1'b1, {(LANES*DW){1'b0}}});
      end else if (we) begin
         for (int i = 0; i < LANES; i++)
            if (wmask[i]) ref_mem[a+i] = wdata[i*DW +: DW];
         exp_q.push_back('0);
      end else begin
         for (int i = 0; i < LANES; i++) rd[i*DW +: DW] = ref_mem[a+i];
         exp_q.push_back({1'b0, rd});
      end
   endtask

   task automatic issue(input logic we, input logic [AW-1:0] addr,
                        input logic [LANES*DW-1:0] wdata, input logic [LANES-1:0] wmask);
      logic acc;
      int   waited;
      acc    = 1'b0;
      waited = 0;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_wmask = wmask;
      bus.req_valid = 1'b1;
      while (!acc) begin
         @(negedge clk);
         acc = bus.req_ready;
         @(posedge clk);
         if (acc) accept_model(we, addr, wdata, wmask);
         else begin
            waited++;
            if (waited > 200) begin
               check("req_accept_timeout", 0, 1);
               break;
            end
         end
      end
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic scan_run(input int n);
      logic [DW:0] e;
      for (int k = 0; k < n; k++) begin
         scan_en = 1'b1;
         e = {scan_ptr_m == 0, ref_mem[HIST + scan_ptr_m]};
         @(posedge clk);
         scan_q.push_back(e);
         last_pix   = e[DW-1:0];
         scan_ptr_m = (scan_ptr_m + 1) % SCAN_TOTAL;
         #1;
      end
      scan_en = 1'b0;
   endtask

   function automatic logic [LANES*DW-1:0] rand_word();
      return {$urandom, $urandom};
   endfunction

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         bus.rsp_ready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: checks every presented response/scan beat against the queues.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.rsp_valid) begin
            if (exp_q.size() == 0) check("rsp_unexpected_valid", bus.rsp_valid, 0);
            else begin
               check("rsp_data", {bus.rsp_err, bus.rsp_rdata}, exp_q[0]);
               if (bus.rsp_ready) void'(exp_q.pop_front());
            end
         end else if (exp_q.size() != 0) begin
            check("rsp_missing_valid", bus.rsp_valid, 1);
         end
         if (scan_q.size() != 0) begin
            check("scan_valid", scan_valid, 1);
            check("scan_sof_pixel", {scan_sof, scan_pixel}, scan_q.pop_front());
         end else if (scan_valid || scan_sof) begin
            check("scan_idle", {scan_valid, scan_sof}, 0);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] a;
      logic [DW:0]   se;
      logic          rdy;
      int            t0;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_wmask = '0;
      bus.rsp_ready = 1'b1;

      #3;
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_rdata", bus.rsp_rdata, 0);
      check("rst_rsp_err", bus.rsp_err, 0);
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_scan", {scan_valid, scan_sof, scan_pixel}, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1 check("req_ready_after_rst", bus.req_ready, 1);

      for (int r = 0; r < TOTAL / LANES; r++) issue(1'b1, AW'(r * LANES), rand_word(), '1);

      issue(1'b0, AW'(64), '0, '0);
      issue(1'b1, AW'(72), 64'h1716151413121110, 8'h0F);
      issue(1'b0, AW'(72), '0, '0);
      issue(1'b0, AW'(3), '0, '0);
      issue(1'b1, AW'(TOTAL), rand_word(), '1);
      issue(1'b0, AW'(TOTAL - LANES), '0, '0);
      issue(1'b0, AW'(1016), '0, '0);
      issue(1'b1, AW'(1023), rand_word(), '1);
      issue(1'b1, AW'(80), rand_word(), 8'h00);
      issue(1'b0, AW'(80), '0, '0);
      issue(1'b0, AW'(0), '0, '0);

      // Back-pressure: one response held, request stalled until consumed.
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
      issue(1'b0, AW'(64), '0, '0);
      bus.req_we    = 1'b0;
      bus.req_addr  = AW'(72);
      bus.req_valid = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("bp_req_ready_low", bus.req_ready, 0);
         check("bp_single_rsp", exp_q.size(), 1);
      end
      @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
      issue(1'b0, AW'(72), '0, '0);

      t0 = cyc;
      for (int k = 0; k < 8; k++) issue(1'b0, AW'($urandom_range(0, TOTAL / LANES - 1) * LANES), '0, '0);
      check("throughput_cycles", cyc - t0, 8);

      rand_ready = 1'b1;
      for (int k = 0; k < 150; k++) begin
         case ($urandom_range(0, 9))
            0: a = AW'($urandom_range(0, 1023));
            1: a = AW'($urandom_range(TOTAL / LANES, 1023 / LANES) * LANES);
            default: a = AW'($urandom_range(0, TOTAL / LANES - 1) * LANES);
         endcase
         issue(1'($urandom_range(0, 1)), a, rand_word(), 8'($urandom_range(0, 255)));
      end
      rand_ready = 1'b0;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("drain_random", exp_q.size(), 0);

      // Scan: first pixel, read-first collision, full wrap.
      issue(1'b1, AW'(HIST), {{(LANES*DW-8){1'b0}}, 8'hAA}, 8'h01);
      scan_run(1);
      scan_en = 1'b1;
      se = {scan_ptr_m == 0, ref_mem[HIST + scan_ptr_m]};
      bus.req_we    = 1'b1;
      bus.req_addr  = AW'(HIST);
      bus.req_wdata = {{(LANES*DW-16){1'b0}}, ref_mem[HIST+1] ^ 8'hFF, 8'h00};
      bus.req_wmask = 8'h02;
      bus.req_valid = 1'b1;
      @(negedge clk);
      rdy = bus.req_ready;
      @(posedge clk);
      scan_q.push_back(se);
      scan_ptr_m = scan_ptr_m + 1;
      if (rdy) accept_model(1'b1, AW'(HIST), bus.req_wdata, 8'h02);
      else check("rf_req_ready", rdy, 1);
      #1;
      scan_en = 1'b0;
      bus.req_valid = 1'b0;
      scan_run(SCAN_TOTAL);
      @(posedge clk);
      @(posedge clk);
      #1 check("scan_pixel_hold", scan_pixel, last_pix);

      // Asynchronous reset with a held response and a stalled write.
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
      issue(1'b0, AW'(72), '0, '0);
      bus.req_we    = 1'b1;
      bus.req_addr  = AW'(HIST);
      bus.req_wdata = {8{8'hEE}};
      bus.req_wmask = '1;
      bus.req_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("arst_rsp_valid", bus.rsp_valid, 0);
      check("arst_req_ready", bus.req_ready, 0);
      check("arst_rsp_rdata", {bus.rsp_err, bus.rsp_rdata}, 0);
      check("arst_scan", {scan_valid, scan_sof, scan_pixel}, 0);
      exp_q.delete();
      scan_q.delete();
      scan_ptr_m = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      rst_n = 1'b1;
      #1 check("rel_req_ready", bus.req_ready, 1);
      issue(1'b0, AW'(HIST), '0, '0);
      issue(1'b0, AW'(72), '0, '0);
      scan_run(1);
      repeat (3) @(posedge clk);
      #1;
      check("final_rsp_q_empty", exp_q.size(), 0);
      check("final_scan_q_empty", scan_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/vector_bank_memory.md
Name: vector_bank_memory

Overview:
- Parametrised successor to the single-region vector memory: one histogram region plus NUM_BANKS image banks in one flat element address space.
- Serves true LANES-wide vector reads and writes (distinct consecutive elements per lane, not one replicated byte).
- Adds per-lane write masks, a valid/ready request handshake with response back-pressure, an error flag, and a free-running display scan port on the same clock.
- Sits between the vector datapath load/store unit and the display/VGA front end.

Parameters:
- DW, 8: element width in bits.
- LANES, 8: elements per vector access; power of two.
- HIST_DEPTH, 512: histogram region size in elements; multiple of LANES.
- NUM_BANKS, 5: number of image banks; at least 1.
- BANK_DEPTH, 65536: elements per image bank; multiple of LANES.
- AW, 20: element address width. The elaboration check requires HIST_DEPTH + NUM_BANKS*BANK_DEPTH <= 2^AW.

Ports:
- clk, in, 1: sole clock.
- rst_n, in, 1: asynchronous active-low reset.
- req_valid, in, 1: request present.
- req_ready, out, 1: request accepted when req_valid and req_ready are both high at the rising edge.
- req_we, in, 1: 1 = write, 0 = read.
- req_addr, in, AW: element address of lane 0.
- req_wdata, in, LANES*DW: lane i occupies bits [i*DW +: DW].
- req_wmask, in, LANES: per-lane write enable.
- rsp_valid, out, 1: response present.
- rsp_ready, in, 1: response consumed.
- rsp_rdata, out, LANES*DW: read data, lane i = element at req_addr+i.
- rsp_err, out, 1: request was misaligned or out of range.
- scan_en, in, 1: advance the display scan.
- scan_valid, out, 1: scan_pixel is updated this cycle.
- scan_pixel, out, DW: display pixel.
- scan_sof, out, 1: scan_pixel is element 0 of bank 0.

Behaviour:
- Reset (async assert, sync deassert): rsp_valid=0, rsp_rdata=0, rsp_err=0, scan_valid=0, scan_pixel=0, scan_sof=0, scan pointer=0.
  - req_ready is 0 while rst_n is low.
  - Memory contents are not cleared.
  - A request in flight at reset is dropped: no response and no write.
- Handshake:
  - req_ready = rst_n && (!rsp_valid || rsp_ready).
  - Response latency is exactly 1 cycle: accepted at edge k, so rsp_valid=1 after edge k.
  - The response holds stable while rsp_valid && !rsp_ready.
  - Accept and consume may occur at the same edge (full throughput, one request per cycle).
  - rsp_valid clears when consumed and no new request is accepted.
- Address decode, for accepted address A:
  - A < HIST_DEPTH: histogram region, offset A.
  - Otherwise b = (A-HIST_DEPTH)/BANK_DEPTH and offset = (A-HIST_DEPTH)%BANK_DEPTH, valid while b < NUM_BANKS.
- Error conditions:
  - A % LANES != 0 is misaligned.
  - A >= HIST_DEPTH + NUM_BANKS*BANK_DEPTH is out of range.
  - On either: rsp_err=1, rsp_rdata=0, no lane written.
  - Aligned accesses never straddle regions.
- Write: lanes with req_wmask[i]=1 store req_wdata lane i at offset+i. rsp_rdata=0, rsp_err=0, and a response is still issued as an acknowledgement. req_wmask=0 gives an acknowledgement with no change.
- Read: rsp_rdata holds the contents at the accept edge. A write in the cycle immediately before is visible.
- Scan:
  - Covers image banks only, as a linear index 0..NUM_BANKS*BANK_DEPTH-1 (bank 0 first).
  - On an edge with scan_en=1: scan_pixel <= element[ptr], scan_valid <= 1, scan_sof <= (ptr==0), ptr advances and wraps to 0 after the last element.
  - On an edge with scan_en=0: scan_valid=0, scan_sof=0, scan_pixel and ptr hold.
  - Scan read and request write to the same element on the same edge: the scan returns old data (read-first).
- Widths: address arithmetic uses AW bits with no truncation. Out-of-range is detected before any subtraction.

Test Plan:
- Reset → all outputs zero. Release reset → req_ready=1. Read A=512 → rsp_valid next cycle, rsp_err=0, data lanes are the preloaded bank0[0..7].
- Write A=520, wdata lanes 0..7 = 0x10..0x17, wmask=0x0F. Then read A=520 → lanes 0..3 = 0x10..0x13, lanes 4..7 unchanged.
- Read A=3 → rsp_err=1, rsp_rdata=0. Write A=328192 (= 512 + 5*65536) → rsp_err=1 and memory unchanged.
- Hold rsp_ready=0 with req_valid=1 continuously → exactly one response and req_ready=0 until consumed. Then set rsp_ready=1 → one response per cycle, in order.
- Write A=512 lane0=0xAA. Pulse scan_en for 1 cycle from ptr=0 → scan_valid=1, scan_sof=1, scan_pixel=0xAA. Run 327680 more scan_en cycles → scan_sof asserts again on the wrap.
- Assert rst_n=0 mid-stream with rsp_valid=1 → rsp_valid=0 immediately (async). After release, scan ptr=0 and earlier written data is intact.
